// File: rtl/csr_loader.sv
// Builds a CSR image (values, column indices, row pointers) in three RAM write ports
// from a row-major stream of non-zero triplets.
module csr_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_ROWS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_row,
  input  logic [DATA_W-1:0] in_col,
  input  logic [DATA_W-1:0] in_val,
  input  logic              in_last,
  output logic              val_we,
  output logic [ADDR_W-1:0] val_addr,
  output logic [DATA_W-1:0] val_din,
  output logic              col_we,
  output logic [ADDR_W-1:0] col_addr,
  output logic [DATA_W-1:0] col_din,
  output logic              row_we,
  output logic [ADDR_W-1:0] row_addr,
  output logic [DATA_W-1:0] row_din,
  output logic [ADDR_W-1:0] nnz,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StDone, StErr} state_e;

  localparam logic [ADDR_W:0]   RowLast = (ADDR_W+1)'(N_ROWS);
  localparam logic [ADDR_W:0]   RowOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] NnzMax  = '1;
  localparam logic [ADDR_W-1:0] NnzOne  = ADDR_W'(1);

  state_e r_state, w_state_next;

  // next_row needs one extra bit: it reaches N_ROWS+1 after the terminating entry
  logic [ADDR_W:0]   r_next_row;
  logic [ADDR_W-1:0] r_nnz;

  logic              r_val_we, r_col_we, r_row_we;
  logic [ADDR_W-1:0] r_val_addr, r_col_addr, r_row_addr;
  logic [DATA_W-1:0] r_val_din, r_col_din, r_row_din;

  logic [ADDR_W:0] w_row;
  logic            w_bad_range, w_bad_order, w_catch_up, w_match, w_overflow;
  logic            w_accept, w_row_wr, w_start_ok;

  assign w_row       = {1'b0, in_row};
  assign w_bad_range = w_row >= RowLast;
  assign w_bad_order = (r_next_row != '0) && (w_row < (r_next_row - RowOne));
  assign w_catch_up  = in_valid && !w_bad_range && !w_bad_order && (w_row >= r_next_row);
  // Remaining legal case: in_row == next_row-1, the row currently being filled
  assign w_match     = in_valid && !w_bad_range && !w_bad_order && !w_catch_up;
  assign w_overflow  = w_match && (r_nnz == NnzMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StErr: begin
        if (start) w_state_next = StLoad;
      end
      StLoad: begin
        if (in_valid && (w_bad_range || w_bad_order || w_overflow)) begin
          w_state_next = StErr;
        end else if (w_match && in_last) begin
          w_state_next = StFill;
        end
      end
      StFill: begin
        if (r_next_row == RowLast) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    w_accept   = 1'b0;
    w_row_wr   = 1'b0;
    w_start_ok = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (r_state)
      StIdle: w_start_ok = start;
      StLoad: begin
        busy     = 1'b1;
        in_ready = w_match;
        w_accept = w_match && !w_overflow;
        w_row_wr = w_catch_up;
      end
      StFill: begin
        busy     = 1'b1;
        w_row_wr = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      StErr: begin
        err        = 1'b1;
        w_start_ok = start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_next_row <= '0;
      r_nnz      <= '0;
      r_val_we   <= 1'b0;
      r_val_addr <= '0;
      r_val_din  <= '0;
      r_col_we   <= 1'b0;
      r_col_addr <= '0;
      r_col_din  <= '0;
      r_row_we   <= 1'b0;
      r_row_addr <= '0;
      r_row_din  <= '0;
    end else begin
      r_val_we <= w_accept;
      r_col_we <= w_accept;
      r_row_we <= w_row_wr;
      if (w_start_ok) begin
        r_next_row <= '0;
        r_nnz      <= '0;
      end
      if (w_accept) begin
        r_val_addr <= r_nnz;
        r_val_din  <= in_val;
        r_col_addr <= r_nnz;
        r_col_din  <= in_col;
        r_nnz      <= r_nnz + NnzOne;
      end
      if (w_row_wr) begin
        r_row_addr <= r_next_row[ADDR_W-1:0];
        r_row_din  <= DATA_W'(r_nnz);
        r_next_row <= r_next_row + RowOne;
      end
    end
  end

  assign val_we   = r_val_we;
  assign val_addr = r_val_addr;
  assign val_din  = r_val_din;
  assign col_we   = r_col_we;
  assign col_addr = r_col_addr;
  assign col_din  = r_col_din;
  assign row_we   = r_row_we;
  assign row_addr = r_row_addr;
  assign row_din  = r_row_din;
  assign nnz      = r_nnz;

endmodule
